meas_chal_loader: RTL and testbench
===================================

Name: meas_chal_loader

Overview:
- Writes the challenge memory that the measurement sequencer reads oscillator mux-select pairs from.
- Receives a serial bit stream of selector bytes from the host side and assembles each byte MSB first.
- Range-checks each byte, checks each pair for distinct selectors, and writes the bytes to sequential memory addresses.
- Reports completion and error status for the whole load.

Parameters:
C_IOSCNUM, 48, number of ring oscillators; a valid selector is 0..C_IOSCNUM-1
C_OIDWIDTH, 24, number of challenge pairs, equal to the number of response bits
C_MEMDATAWIDTH, 8, selector byte width and memory data width
C_MEMADDRWIDTH, 24, memory address width
C_BASEADDR, 0, address of the first selector byte

Ports:
I_sclk  input  1  system clock; all logic on posedge
I_rst  input  1  asynchronous, active-low reset
I_load  input  1  one-cycle pulse: start a new load, aborting any load in progress
I_sdi  input  1  serial selector data, MSB of each byte first
I_sdi_vld  input  1  I_sdi is sampled on this cycle
O_mem_addr  output  C_MEMADDRWIDTH  write address
O_mem_data  output  C_MEMDATAWIDTH  write data
O_mem_we  output  1  one-cycle write strobe
O_busy  output  1  load in progress
O_done  output  1  sticky: all 2*C_OIDWIDTH bytes written without error
O_err  output  1  sticky: load rejected
O_err_idx  output  C_MEMADDRWIDTH  byte index (0-based) of the first offending byte

Behaviour:
- Reset (I_rst=0, asynchronous): state IDLE; all outputs 0; bit counter, byte counter and held selector cleared.
- States:
  - IDLE: waits for I_load.
  - LOAD: accepts bits.
  - DONE: holds O_done=1.
  - ERR: holds O_err=1.
- I_load=1 in any state:
  - next state LOAD; clears O_done, O_err, O_err_idx, bit counter and byte counter.
  - any partially assembled byte is discarded.
  - I_sdi_vld in the same cycle as I_load is ignored.
- LOAD, bit acceptance:
  - O_busy=1.
  - each I_sdi_vld=1 cycle shifts I_sdi into an 8-bit shift register (shift left, new bit into LSB).
  - bits may arrive on every consecutive cycle; there is no backpressure.
- Byte completion: on the 8th accepted bit the byte b with index k is registered. In the following cycle exactly one of:
  - b >= C_IOSCNUM: no write; O_err=1; O_err_idx=k; state ERR.
  - k odd and b equals the held even selector (same oscillator on both mux inputs): no write; O_err=1; O_err_idx=k; state ERR.
  - otherwise:
    - O_mem_we=1 for one cycle, O_mem_addr=C_BASEADDR+k, O_mem_data=b.
    - if k is even, b is held as the even selector of the pair.
    - byte counter increments.
- Pair layout: pair p sits at C_BASEADDR+2p (mux 1 selector) and C_BASEADDR+2p+1 (mux 2 selector).
- Pipelining: the write/check cycle overlaps acceptance of the next byte's first bit. Write latency is 1 cycle after the 8th bit.
- Completion:
  - after the write of byte index 2*C_OIDWIDTH-1: O_done=1 and O_busy=0 from the next cycle; state DONE.
  - in DONE or ERR, I_sdi_vld is ignored.
- O_mem_addr and O_mem_data hold their last value when O_mem_we=0.
- O_done and O_err are never 1 together.
- An earlier valid byte of a rejected load may already be written. Consumers must check O_done before starting a measurement.
- Reset mid-load: immediate return to IDLE; no further writes.
- Counters:
  - byte counter width clog2(2*C_OIDWIDTH)+1; never wraps, because the load ends at 2*C_OIDWIDTH bytes.
  - bit counter 3 bits, wraps 7->0 at byte completion.

Test Plan:
- Reset, then I_load. Send 48 bytes, pairs (0,1),(2,3)...(46,47), one bit per cycle. Expect:
  - 48 O_mem_we pulses, address n holding data n, each pulse 1 cycle after the byte's 8th bit.
  - O_done=1 after the last write; O_busy=0; O_err=0.
- Send bytes 5, 48 at the start of a load. Expect:
  - one write (addr 0, data 5).
  - O_err=1, O_err_idx=1; state ERR; later I_sdi_vld produces no writes.
- Send pair (7,7) as bytes 2 and 3 after a valid pair (0,1). Expect writes at addresses 0, 1, 2 only; O_err=1, O_err_idx=3.
- Send 20 bits with I_sdi_vld gapped randomly, assert I_load, then send a full valid load of 48 bytes. Expect:
  - the first write lands at C_BASEADDR with the first new byte.
  - the 4 stale bits are discarded; O_done=1.
- Deassert I_rst while byte 10 is being shifted. Expect all outputs 0 asynchronously and no further O_mem_we until the next I_load.
- Complete a valid load, then toggle I_sdi_vld for 16 cycles. Expect no O_mem_we and O_done stays 1. Then assert I_load and expect O_done to clear the next cycle.

Source files
------------

// File: rtl/meas_chal_loader_if.sv
// Host-side load stream and challenge-memory write port of meas_chal_loader.
// The loader takes the slave modport; the host or bench takes the master modport.
interface meas_chal_loader_if #(
    parameter int C_MEMADDRWIDTH = 24,
    parameter int C_MEMDATAWIDTH = 8
);
    logic                      I_load;
    logic                      I_sdi;
    logic                      I_sdi_vld;
    logic [C_MEMADDRWIDTH-1:0] O_mem_addr;
    logic [C_MEMDATAWIDTH-1:0] O_mem_data;
    logic                      O_mem_we;
    logic                      O_busy;
    logic                      O_done;
    logic                      O_err;
    logic [C_MEMADDRWIDTH-1:0] O_err_idx;

    modport master (
        output I_load, I_sdi, I_sdi_vld,
        input  O_mem_addr, O_mem_data, O_mem_we, O_busy, O_done, O_err, O_err_idx
    );

    modport slave (
        input  I_load, I_sdi, I_sdi_vld,
        output O_mem_addr, O_mem_data, O_mem_we, O_busy, O_done, O_err, O_err_idx
    );
endinterface

// File: rtl/meas_chal_loader.sv
// Assembles serial selector bytes (MSB first) and range-checks them. It rejects
// pairs that use the same oscillator twice and writes the bytes to challenge memory.
module meas_chal_loader #(
    parameter int C_IOSCNUM      = 48,
    parameter int C_OIDWIDTH     = 24,
    parameter int C_MEMDATAWIDTH = 8,
    parameter int C_MEMADDRWIDTH = 24,
    parameter int C_BASEADDR     = 0
) (
    input  logic              I_sclk,
    input  logic              I_rst,
    meas_chal_loader_if.slave bus
);
    localparam int CW = $clog2(2 * C_OIDWIDTH) + 1;
    localparam int BW = $clog2(C_MEMDATAWIDTH);
    localparam int DW = C_MEMDATAWIDTH;
    localparam int AW = C_MEMADDRWIDTH;

    localparam logic [CW-1:0] LAST_IDX = CW'(2 * C_OIDWIDTH - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);
    localparam logic [DW:0]   OSC_LIM  = (DW + 1)'(C_IOSCNUM);
    localparam logic [AW-1:0] BASE     = AW'(C_BASEADDR);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] shreg;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] byte_cnt;
    logic [DW-1:0] even_sel;
    logic          fin;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [AW-1:0] err_idx;

    logic          accept;
    logic          byte_end;
    logic [DW-1:0] byte_nx;
    logic          bad;

    // fin marks that the last byte's write is on the bus. DONE follows one cycle
    // after that write, and bits arriving in between are ignored.
    assign accept   = (state == S_LOAD) && !fin && bus.I_sdi_vld && !bus.I_load;
    assign byte_end = accept && (bit_cnt == LAST_BIT);
    assign byte_nx  = {shreg[DW-2:0], bus.I_sdi};
    assign bad      = ({1'b0, byte_nx} >= OSC_LIM) ||
                      (byte_cnt[0] && (byte_nx == even_sel));

    always_ff @(posedge I_sclk or negedge I_rst) begin
        if (!I_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.I_load) begin
            state_nx = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (fin)                 state_nx = S_DONE;
                    else if (byte_end && bad) state_nx = S_ERR;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge I_sclk or negedge I_rst) begin
        if (!I_rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            even_sel <= '0;
            fin      <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            err_idx  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (bus.I_load) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                even_sel <= '0;
                fin      <= 1'b0;
                err_idx  <= '0;
            end else if (accept) begin
                shreg   <= byte_nx;
                bit_cnt <= bit_cnt + 1'b1;
                if (byte_end) begin
                    if (bad) begin
                        err_idx <= AW'(byte_cnt);
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= BASE + AW'(byte_cnt);
                        mem_data <= byte_nx;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (!byte_cnt[0]) even_sel <= byte_nx;
                        if (byte_cnt == LAST_IDX) fin <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.O_mem_addr = mem_addr;
    assign bus.O_mem_data = mem_data;
    assign bus.O_mem_we   = mem_we;
    assign bus.O_busy     = (state == S_LOAD);
    assign bus.O_done     = (state == S_DONE);
    assign bus.O_err      = (state == S_ERR);
    assign bus.O_err_idx  = err_idx;
endmodule

// File: tb/tb_meas_chal_loader.sv
// Directed bench for meas_chal_loader. Expected write addresses and data, flags,
// error indices and write latency are worked out by hand from the input vectors.
module tb_meas_chal_loader;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   wr_cnt;
    logic [23:0] wa [0:63];
    logic [7:0]  wd [0:63];
    logic eighth;
    logic eighth_q;

    meas_chal_loader_if #(.C_MEMADDRWIDTH(24), .C_MEMDATAWIDTH(8)) bus ();

    meas_chal_loader #(
        .C_IOSCNUM(48), .C_OIDWIDTH(24), .C_MEMDATAWIDTH(8),
        .C_MEMADDRWIDTH(24), .C_BASEADDR(0)
    ) dut (
        .I_sclk(clk),
        .I_rst(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A write must appear in the cycle right after an 8th bit was sampled.
    always @(posedge clk) eighth_q <= eighth;
    always @(negedge clk) begin
        if (bus.O_mem_we === 1'b1) begin
            chk("we_latency", {31'b0, eighth_q}, 32'd1);
            if (wr_cnt < 64) begin
                wa[wr_cnt] = bus.O_mem_addr;
                wd[wr_cnt] = bus.O_mem_data;
            end
            wr_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.I_sdi_vld = 1'b0;
            eighth = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input logic last);
        @(negedge clk);
        bus.I_sdi     = b;
        bus.I_sdi_vld = 1'b1;
        eighth        = last;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == 0);
    endtask

    task automatic pulse_load(input logic with_vld);
        @(negedge clk);
        wr_cnt        = 0;
        bus.I_load    = 1'b1;
        bus.I_sdi_vld = with_vld;
        bus.I_sdi     = 1'b1;
        eighth        = 1'b0;
        @(negedge clk);
        bus.I_load    = 1'b0;
        bus.I_sdi_vld = 1'b0;
    endtask

    task automatic full_load();
        for (int n = 0; n < 48; n++) send_byte(8'(n));
    endtask

    task automatic chk_writes(input string tag, input int n);
        int bad_cnt;
        bad_cnt = 0;
        for (int i = 0; i < n && i < 64; i++)
            if (wa[i] !== 24'(i) || wd[i] !== 8'(i)) bad_cnt++;
        chk(tag, bad_cnt, 0);
    endtask

    initial begin
        checks = 0; errors = 0; wr_cnt = 0;
        eighth = 1'b0;
        rst_n = 1'b0;
        bus.I_load = 1'b0; bus.I_sdi = 1'b0; bus.I_sdi_vld = 1'b0;
        idle(3);
        chk("rst_busy", bus.O_busy, 0);
        chk("rst_done", bus.O_done, 0);
        chk("rst_err", bus.O_err, 0);
        chk("rst_we", bus.O_mem_we, 0);
        chk("rst_addr", bus.O_mem_addr, 0);
        chk("rst_data", bus.O_mem_data, 0);
        chk("rst_err_idx", bus.O_err_idx, 0);
        rst_n = 1'b1;
        idle(2);

        // Full valid load of pairs (0,1)..(46,47)
        pulse_load(1'b0);
        chk("load_busy", bus.O_busy, 1);
        full_load();
        @(negedge clk);
        bus.I_sdi_vld = 1'b0; eighth = 1'b0;
        chk("last_we", bus.O_mem_we, 1);
        chk("last_done_early", bus.O_done, 0);
        chk("last_busy", bus.O_busy, 1);
        @(negedge clk);
        chk("full_done", bus.O_done, 1);
        chk("full_busy", bus.O_busy, 0);
        chk("full_err", bus.O_err, 0);
        idle(2);
        chk("full_wr_cnt", wr_cnt, 48);
        chk_writes("full_contents", 48);

        // Out-of-range selector at index 1
        pulse_load(1'b0);
        send_byte(8'd5);
        send_byte(8'd48);
        idle(2);
        chk("range_err", bus.O_err, 1);
        chk("range_done", bus.O_done, 0);
        chk("range_err_idx", bus.O_err_idx, 1);
        chk("range_busy", bus.O_busy, 0);
        chk("range_wr_cnt", wr_cnt, 1);
        chk("range_wa0", wa[0], 0);
        chk("range_wd0", wd[0], 5);
        for (int i = 0; i < 16; i++) send_bit(i[0], 1'b0);
        idle(2);
        chk("range_no_more_wr", wr_cnt, 1);
        chk("range_err_held", bus.O_err, 1);

        // Duplicate selector pair (7,7) after (0,1)
        pulse_load(1'b0);
        send_byte(8'd0); send_byte(8'd1); send_byte(8'd7); send_byte(8'd7);
        idle(2);
        chk("dup_err", bus.O_err, 1);
        chk("dup_err_idx", bus.O_err_idx, 3);
        chk("dup_wr_cnt", wr_cnt, 3);
        chk("dup_wa2", wa[2], 2);
        chk("dup_wd2", wd[2], 7);

        // Gapped partial load aborted by a new load, with a stray vld on the load cycle
        pulse_load(1'b0);
        for (int i = 0; i < 20; i++) begin
            idle($urandom_range(0, 2));
            send_bit(1'($urandom_range(0, 1)), (i % 8) == 7);
        end
        idle(1);
        pulse_load(1'b1);
        full_load();
        idle(3);
        chk("abort_wr_cnt", wr_cnt, 48);
        chk("abort_wa0", wa[0], 0);
        chk("abort_wd0", wd[0], 0);
        chk_writes("abort_contents", 48);
        chk("abort_done", bus.O_done, 1);
        chk("abort_err", bus.O_err, 0);

        // Asynchronous reset while byte 10 is being shifted
        pulse_load(1'b0);
        for (int n = 0; n < 10; n++) send_byte(8'(n));
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.O_busy, 0);
        chk("arst_we", bus.O_mem_we, 0);
        chk("arst_addr", bus.O_mem_addr, 0);
        chk("arst_data", bus.O_mem_data, 0);
        chk("arst_err_idx", bus.O_err_idx, 0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send_bit(1'b0, 1'b0);
        idle(2);
        chk("arst_wr_cnt", wr_cnt, 10);
        chk("arst_idle_busy", bus.O_busy, 0);

        // Valid load, then vld toggling in DONE, then restart
        pulse_load(1'b0);
        full_load();
        idle(3);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.I_sdi_vld = i[0];
            bus.I_sdi     = 1'b0;
        end
        idle(2);
        chk("post_wr_cnt", wr_cnt, 48);
        chk("post_done", bus.O_done, 1);
        pulse_load(1'b0);
        chk("reload_done", bus.O_done, 0);
        chk("reload_busy", bus.O_busy, 1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
